seq_mul4_ctrl: RTL



---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/rca.sv | 25 ++
 rtl/seq_mul4_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the
// sequential shift-add multiplier.
package seq_mul_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca.sv
// N-bit ripple-carry adder built from
// a chain of full-adder cells.
module rca #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/seq_mul4_ctrl.sv
// Shift-add multiplier controller sharing
// one rca for every partial-product step.
module seq_mul4_ctrl
  import seq_mul_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_w(N);

  state_t         state;
  state_t         nstate;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mq;
  logic [N-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           c;
  logic           load;
  logic           last;
  logic [2*N-1:0] shifted;

  assign addend  = mq[0] ? mcand : '0;
  assign last    = (cnt == CW'(N - 1));
  assign shifted = {c, sum, mq[N-1:1]};

  rca #(
    .N(N)
  ) u_rca (
    .a   (acc),
    .b   (addend),
    .cin (1'b0),
    .sum (sum),
    .cout(c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next state, handshake outputs, accept
  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    load   = 1'b0;
    unique case (1'b1)
      (state == RUN): begin
        busy = 1'b1;
        if (last) nstate = DONE;
      end
      (state == DONE): begin
        done = 1'b1;
        load = start;
        nstate = start ? RUN : IDLE;
      end
      default: begin
        load = start;
        nstate = start ? RUN : IDLE;
      end
    endcase
  end

  // Operand capture and shift-add datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mq      <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      mcand <= a;
      mq    <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      {acc, mq} <= shifted;
      cnt       <= cnt + CW'(1);
      if (last) product <= shifted;
    end
  end

endmodule
